// File: rtl/sift_dir_quant_pipe.sv
// ---------------------------------------------------------------------------
// sift_dir_quant_pipe
//
// Pipelined gradient-orientation quantiser for the SIFT orientation and
// descriptor stages. Maps a signed gradient (dx, dy) to the nearest of NBINS
// orientation bins without a lookup table. The gradient is folded into the
// first octant, a small set of fixed-point tangent thresholds picks the
// sub-octant, and the octant/quadrant information unfolds it again. The
// resulting bin is rotated by a keypoint's dominant orientation (ref_dir).
//
// Three register stages, one result per clock, with a single global stall
// enable driven by the output handshake.
//
// Parameters
//   GW     signed gradient width of dx/dy
//   NBINS  number of orientation bins (8, 16 or 32); BW = log2(NBINS)
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   in_valid   in   1       dx / dy / ref_dir valid
//   in_ready   out  1       block accepts an input this cycle
//   dx         in   GW      signed x gradient
//   dy         in   GW      signed y gradient (+y is counter-clockwise)
//   ref_dir    in   BW      dominant-orientation bin subtracted from result
//   out_valid  out  1       result valid
//   out_ready  in   1       downstream accepts the result
//   dir        out  BW      (bin - ref_dir) mod NBINS
//   zero_grad  out  1       gradient was exactly zero
//   mag        out  GW+1    approximate magnitude hi + lo/2
//                           (present only when SIFT_DIR_MAG_EN is defined)
//
// Optional feature macro: SIFT_DIR_MAG_EN
// ---------------------------------------------------------------------------
module sift_dir_quant_pipe #(
    parameter int GW    = 9,
    parameter int NBINS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [GW-1:0]              dx,
    input  logic [GW-1:0]              dy,
    input  logic [$clog2(NBINS)-1:0]   ref_dir,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NBINS)-1:0]   dir,
    output logic                       zero_grad
`ifdef SIFT_DIR_MAG_EN
    ,
    output logic [GW:0]                mag
`endif
);

    localparam int BW = $clog2(NBINS);
    localparam int M  = NBINS / 8;
    localparam int PW = GW + 8;

    localparam logic [BW-1:0] ONE       = BW'(1);
    localparam logic [BW-1:0] TWO_M     = BW'(2 * M);
    localparam logic [BW-1:0] HALF_TURN = BW'(4 * M);

    generate
        if (NBINS != 8 && NBINS != 16 && NBINS != 32) begin : g_bad_nbins
            $error("sift_dir_quant_pipe: NBINS must be 8, 16 or 32");
        end
    endgenerate

    // Q8 tangent thresholds tan((2i+1) * 180/NBINS deg) * 256 for the
    // sub-octant boundaries; index i runs 0..M-1.
    function automatic logic [7:0] thr(input int idx);
        logic [7:0] t;
        t = 8'd0;
        if (NBINS == 8) begin
            t = 8'd106;
        end else if (NBINS == 16) begin
            t = (idx == 0) ? 8'd51 : 8'd171;
        end else begin
            case (idx)
                0:       t = 8'd25;
                1:       t = 8'd78;
                2:       t = 8'd137;
                default: t = 8'd210;
            endcase
        end
        return t;
    endfunction

    logic en;

    // The whole pipe advances together: it moves whenever the output
    // register is empty or being drained this cycle.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // -----------------------------------------------------------------------
    // Stage 1: fold into the first octant
    // -----------------------------------------------------------------------
    logic [GW-1:0] ax, ay;
    logic          swp;

    // Magnitudes are GW-bit unsigned, so -2^(GW-1) folds to 2^(GW-1) exactly.
    assign ax  = dx[GW-1] ? (~dx + 1'b1) : dx;
    assign ay  = dy[GW-1] ? (~dy + 1'b1) : dy;
    assign swp = ay > ax;

    logic          v1, sx1, sy1, swp1, zero1;
    logic [GW-1:0] lo1, hi1;
    logic [BW-1:0] ref1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            sx1   <= 1'b0;
            sy1   <= 1'b0;
            swp1  <= 1'b0;
            zero1 <= 1'b0;
            lo1   <= '0;
            hi1   <= '0;
            ref1  <= '0;
        end else if (en) begin
            v1    <= in_valid;
            sx1   <= dx[GW-1];
            sy1   <= dy[GW-1];
            swp1  <= swp;
            zero1 <= (ax == '0) && (ay == '0);
            lo1   <= swp ? ax : ay;
            hi1   <= swp ? ay : ax;
            ref1  <= ref_dir;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: sub-octant index by threshold comparison
    // -----------------------------------------------------------------------
    // c counts thresholds with lo/hi >= T/256; an equality lands in the
    // higher bin. lo == hi (diagonal or zero) passes every threshold, c = M.
    logic [BW-1:0] c_cnt;
    logic [PW-1:0] prod_lo, prod_t;

    always_comb begin
        c_cnt   = '0;
        prod_lo = {lo1, 8'h00};
        prod_t  = '0;
        for (int i = 0; i < M; i++) begin
            prod_t = PW'(thr(i)) * PW'(hi1);
            if (prod_lo >= prod_t) begin
                c_cnt = c_cnt + ONE;
            end
        end
    end

    logic          v2, sx2, sy2, swp2, zero2;
    logic [BW-1:0] c2, ref2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            sx2   <= 1'b0;
            sy2   <= 1'b0;
            swp2  <= 1'b0;
            zero2 <= 1'b0;
            c2    <= '0;
            ref2  <= '0;
        end else if (en) begin
            v2    <= v1;
            sx2   <= sx1;
            sy2   <= sy1;
            swp2  <= swp1;
            zero2 <= zero1;
            c2    <= c_cnt;
            ref2  <= ref1;
        end
    end

`ifdef SIFT_DIR_MAG_EN
    logic [GW:0] mag2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag2 <= '0;
        end else if (en) begin
            mag2 <= {1'b0, hi1} + {2'b00, lo1[GW-1:1]};
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Stage 3: unfold octant and quadrant, rotate by ref_dir
    // -----------------------------------------------------------------------
    logic [BW-1:0] q, bin;

    // All arithmetic is BW-bit, so 8M - q and bin - ref wrap mod NBINS.
    always_comb begin
        q   = swp2 ? (TWO_M - c2) : c2;
        bin = q;
        case ({sx2, sy2})
            2'b00:   bin = q;
            2'b10:   bin = HALF_TURN - q;
            2'b11:   bin = HALF_TURN + q;
            default: bin = '0 - q;
        endcase
        if (zero2) begin
            bin = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            dir       <= '0;
            zero_grad <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            dir       <= bin - ref2;
            zero_grad <= zero2;
        end
    end

`ifdef SIFT_DIR_MAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag <= '0;
        end else if (en) begin
            mag <= mag2;
        end
    end
`endif

endmodule

// File: tb/tb_sift_dir_quant_pipe.sv
// ---------------------------------------------------------------------------
// tb_sift_dir_quant_pipe
//
// Directed self-checking bench for sift_dir_quant_pipe (GW=9, NBINS=32).
// Expected bins are hand-computed from the octant/threshold definition.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Define SIFT_DIR_MAG_EN to also exercise the magnitude output.
// ---------------------------------------------------------------------------
module tb_sift_dir_quant_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [4:0] ref_dir;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] dir;
    logic       zero_grad;
`ifdef SIFT_DIR_MAG_EN
    logic [9:0] mag;
    logic [9:0] obs_mag;
`endif

    int checks   = 0;
    int failures = 0;

    sift_dir_quant_pipe #(
        .GW    (9),
        .NBINS (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dx        (dx),
        .dy        (dy),
        .ref_dir   (ref_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dir       (dir),
        .zero_grad (zero_grad)
`ifdef SIFT_DIR_MAG_EN
        ,
        .mag       (mag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends one vector into an empty pipe and reports the first result and
    // how many clocks after the accepting edge it appeared (0 = never).
    // Inputs are scrambled after acceptance so ref_dir must be carried.
    task automatic run_vector(input int vdx, input int vdy, input int vr,
                              output logic [4:0] odir, output logic ozero,
                              output int olat);
        olat  = 0;
        odir  = '0;
        ozero = 1'b0;
        @(negedge clk);
        dx       = vdx[8:0];
        dy       = vdy[8:0];
        ref_dir  = vr[4:0];
        in_valid = 1'b1;
        for (int k = 1; k <= 8 && olat == 0; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            dx       = 9'h0AA;
            dy       = 9'h155;
            ref_dir  = ~vr[4:0];
            if (out_valid) begin
                olat  = k;
                odir  = dir;
                ozero = zero_grad;
`ifdef SIFT_DIR_MAG_EN
                obs_mag = mag;
`endif
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dx        = '0;
        dy        = '0;
        ref_dir   = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dir !== 5'd0 || zero_grad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: out_valid=%b dir=%0d zero_grad=%b, required 0/0/0",
                     out_valid, dir, zero_grad);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_axes();
        int tdx[4] = '{100, 0, -100, 0};
        int tdy[4] = '{0, 100, 0, -100};
        int texp[4] = '{0, 8, 16, 24};
        logic [4:0] od;
        logic       oz;
        int         ol;
        for (int i = 0; i < 4; i++) begin
            run_vector(tdx[i], tdy[i], 0, od, oz, ol);
            checks++;
            if (ol != 3) begin
                failures++;
                $display("[TB] FAIL axis_latency[%0d]: got %0d clks, required 3", i, ol);
            end
            checks++;
            if (od !== texp[i][4:0] || oz !== 1'b0) begin
                failures++;
                $display("[TB] FAIL axis_dir[%0d]: got dir=%0d zg=%b, required dir=%0d zg=0",
                         i, od, oz, texp[i]);
            end
        end
    endtask

    task automatic test_diag_boundary();
        int tdx[6] = '{100, -50, 255, 255, -256, -256};
        int tdy[6] = '{-100, 50, 25, 24, 25, 24};
        int texp[6] = '{28, 12, 1, 0, 15, 16};
        logic [4:0] od;
        logic       oz;
        int         ol;
        for (int i = 0; i < 6; i++) begin
            run_vector(tdx[i], tdy[i], 0, od, oz, ol);
            checks++;
            if (ol != 3 || od !== texp[i][4:0]) begin
                failures++;
                $display("[TB] FAIL diag_boundary[%0d]: got dir=%0d lat=%0d, required dir=%0d lat=3",
                         i, od, ol, texp[i]);
            end
        end
    endtask

    task automatic test_extremes_zero();
        int tdx[3] = '{-256, 0, 0};
        int tdy[3] = '{-256, 0, 0};
        int tref[3] = '{0, 0, 5};
        int texp[3] = '{20, 0, 27};
        logic tzg[3] = '{1'b0, 1'b1, 1'b1};
        logic [4:0] od;
        logic       oz;
        int         ol;
        for (int i = 0; i < 3; i++) begin
            run_vector(tdx[i], tdy[i], tref[i], od, oz, ol);
            checks++;
            if (ol != 3 || od !== texp[i][4:0] || oz !== tzg[i]) begin
                failures++;
                $display("[TB] FAIL extreme_zero[%0d]: got dir=%0d zg=%b lat=%0d, required dir=%0d zg=%b lat=3",
                         i, od, oz, ol, texp[i], tzg[i]);
            end
        end
    endtask

    task automatic test_rotation();
        int tdx[3] = '{100, 0, -100};
        int tdy[3] = '{0, 100, 0};
        int tref[3] = '{30, 8, 20};
        int texp[3] = '{2, 0, 28};
        logic [4:0] od;
        logic       oz;
        int         ol;
        for (int i = 0; i < 3; i++) begin
            run_vector(tdx[i], tdy[i], tref[i], od, oz, ol);
            checks++;
            if (ol != 3 || od !== texp[i][4:0]) begin
                failures++;
                $display("[TB] FAIL rotation[%0d]: got dir=%0d lat=%0d, required dir=%0d lat=3",
                         i, od, ol, texp[i]);
            end
        end
    endtask

    task automatic test_back_to_back_backpressure();
        int vdx[8] = '{100, 0, -100, 0, 100, -50, 255, -256};
        int vdy[8] = '{0, 100, 0, -100, -100, 50, 25, -256};
        int vref[8] = '{0, 0, 0, 0, 0, 0, 0, 3};
        int vexp[8] = '{0, 8, 16, 24, 28, 12, 1, 17};
        int tx = 0;
        int rx = 0;
        logic       held = 1'b0;
        logic [4:0] held_dir = '0;
        for (int cyc = 0; cyc < 200 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 2) != 0);
            if (tx < 8) begin
                in_valid = 1'b1;
                dx       = vdx[tx][8:0];
                dy       = vdy[tx][8:0];
                ref_dir  = vref[tx][4:0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== (out_ready | ~out_valid)) begin
                failures++;
                $display("[TB] FAIL bp_in_ready: got %b, required %b", in_ready, out_ready | ~out_valid);
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || dir !== held_dir) begin
                    failures++;
                    $display("[TB] FAIL bp_stall_hold: got valid=%b dir=%0d, required valid=1 dir=%0d",
                             out_valid, dir, held_dir);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (dir !== vexp[rx][4:0]) begin
                    failures++;
                    $display("[TB] FAIL bp_order[%0d]: got dir=%0d, required %0d", rx, dir, vexp[rx]);
                end
                rx++;
                held = 1'b0;
            end else if (out_valid) begin
                held     = 1'b1;
                held_dir = dir;
            end else begin
                held = 1'b0;
            end
            if (in_valid && in_ready) begin
                tx++;
            end
        end
        checks++;
        if (rx != 8) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d results, required 8", rx);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_no_duplicate: got out_valid=%b after drain, required 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int tdx[3] = '{0, -100, 0};
        int tdy[3] = '{100, 0, -100};
        logic [4:0] od;
        logic       oz;
        int         ol;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dx       = tdx[i][8:0];
            dy       = tdy[i][8:0];
            ref_dir  = '0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dir !== 5'd8) begin
            failures++;
            $display("[TB] FAIL midflight_prefill: got valid=%b dir=%0d, required valid=1 dir=8",
                     out_valid, dir);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dir !== 5'd0 || zero_grad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midflight_async_reset: got valid=%b dir=%0d zg=%b, required 0/0/0",
                     out_valid, dir, zero_grad);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_vector(0, 100, 0, od, oz, ol);
        checks++;
        if (ol != 3 || od !== 5'd8) begin
            failures++;
            $display("[TB] FAIL post_reset_first: got dir=%0d lat=%0d, required dir=8 lat=3", od, ol);
        end
`ifdef SIFT_DIR_MAG_EN
        run_vector(100, -40, 0, od, oz, ol);
        checks++;
        if (ol != 3 || od !== 5'd30 || obs_mag !== 10'd120) begin
            failures++;
            $display("[TB] FAIL magnitude: got dir=%0d mag=%0d lat=%0d, required dir=30 mag=120 lat=3",
                     od, obs_mag, ol);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_axes();
        test_diag_boundary();
        test_extremes_zero();
        test_rotation();
        test_back_to_back_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
